alsu_req_arbiter: RTL

//  Shares one ALSU instance (3-bit a/b, 6-bit registered out, error flag) between two requesters.

---
 rtl/alsu_req_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/alsu_req_arbiter.sv
// Round-robin arbiter that shares one ALSU between two requesters. Commands are accepted only
// in IDLE, issued for one cycle, and the captured result is returned to the requester that owns it.
module alsu_req_arbiter #(
  parameter int ALSU_LAT    = 2,
  parameter bit FIRST_GRANT = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [15:0] req0_cmd,
  output logic        resp0_valid,
  input  logic        resp0_ready,
  output logic [5:0]  resp0_data,
  output logic        resp0_err,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [15:0] req1_cmd,
  output logic        resp1_valid,
  input  logic        resp1_ready,
  output logic [5:0]  resp1_data,
  output logic        resp1_err,
  output logic [15:0] alsu_cmd,
  input  logic [5:0]  alsu_out,
  input  logic        alsu_err,
  output logic        busy,
  output logic [7:0]  err_cnt,
  output logic [1:0]  state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // reqN_ready depends combinationally on the valids; respN_valid holds with stable data
  // until respN_ready is seen.

  localparam logic [15:0] IDLE_CMD = 16'h4000;
  localparam int CW = (ALSU_LAT > 1) ? $clog2(ALSU_LAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic          last_grant;
  logic          owner;
  logic          winner;
  logic          accept;
  logic          owner_ready;
  logic          owner_err;

  assign owner_ready = owner ? resp1_ready : resp0_ready;
  assign owner_err   = owner ? resp1_err : resp0_err;
  assign busy        = (state != S_IDLE);
  assign state_dbg   = state;

  always_comb begin
    state_nxt  = state;
    winner     = 1'b0;
    accept     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      S_IDLE: begin
        // On a tie the requester that did not win last time goes next.
        if (req0_valid && req1_valid) winner = ~last_grant;
        else                          winner = req1_valid;
        accept     = req0_valid | req1_valid;
        req0_ready = accept & ~winner;
        req1_ready = accept & winner;
        if (accept) state_nxt = S_ISSUE;
      end
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (cnt == '0) state_nxt = S_RESP;
      S_RESP:  if (owner_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      alsu_cmd    <= IDLE_CMD;
      cnt         <= '0;
      last_grant  <= ~FIRST_GRANT;
      owner       <= 1'b0;
      resp0_valid <= 1'b0;
      resp0_data  <= '0;
      resp0_err   <= 1'b0;
      resp1_valid <= 1'b0;
      resp1_data  <= '0;
      resp1_err   <= 1'b0;
      err_cnt     <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (accept) begin
            alsu_cmd   <= winner ? req1_cmd : req0_cmd;
            owner      <= winner;
            last_grant <= winner;
          end
        end
        S_ISSUE: begin
          // Idle command forces the ALSU output back to 0 so shifts never chain.
          alsu_cmd <= IDLE_CMD;
          cnt      <= CW'(ALSU_LAT - 1);
        end
        S_WAIT: begin
          if (cnt == '0) begin
            if (owner) begin
              resp1_valid <= 1'b1;
              resp1_data  <= alsu_out;
              resp1_err   <= alsu_err;
            end else begin
              resp0_valid <= 1'b1;
              resp0_data  <= alsu_out;
              resp0_err   <= alsu_err;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_RESP: begin
          if (owner_ready) begin
            if (owner) resp1_valid <= 1'b0;
            else       resp0_valid <= 1'b0;
            if (owner_err && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
